// File: rtl/proc_pkg.sv
// Shared definitions for the instruction fetch/decode block and the
// instruction ROM that feeds it.
//
// The package holds:
//   - the opcode values,
//   - the bus source encodings,
//   - the controller state enum,
//   - the bit positions of the instruction fields.
//
// Instruction word layout (23 bits):
//   [22:19] opcode
//   [18:16] Rx
//   [15:0]  imm16 (LOAD)
//   [15:13] Ry    (MOV/ADD)
package proc_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_LOAD = 4'b0001;
  localparam logic [3:0] OP_MOV  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_IMM  = 2'b01;
  localparam logic [1:0] BUS_REG  = 2'b10;
  localparam logic [1:0] BUS_ALU  = 2'b11;

  localparam int OP_LSB  = 19;
  localparam int OP_MSB  = 22;
  localparam int RX_LSB  = 16;
  localparam int RY_LSB  = 13;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC1  = 3'd3,
    EXEC2  = 3'd4,
    HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/instr_fetch_decode.sv
// Instruction fetch/decode controller.
//
// Owns the program counter, drives the instruction ROM address, captures
// the returned code word into the instruction register (IR), and sequences
// the register-file, bus and ALU control strobes for each instruction.
//
// Ports:
//   clock      - system clock, rising edge
//   resetn     - asynchronous active-low reset
//   run        - level input; starts execution from IDLE, restarts it from HALT
//   rom_addr   - ROM address (equals pc)
//   rom_code   - combinational ROM data for rom_addr
//   rf_wr_en   - register-file write strobe
//   rf_wr_sel  - destination register (Rx)
//   rf_rd_sel  - register-file read select
//   imm_out    - IR immediate field, always visible
//   bus_sel    - bus source: 00 none, 01 imm, 10 reg, 11 alu
//   a_load     - latch the bus value into the ALU A register
//   instr_done - pulse in the last cycle of each executed instruction
//   illegal_op - pulse in DECODE on an illegal opcode
//   halted     - high while in HALT
//   pc         - debug copy of the program counter
module instr_fetch_decode
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int INSTR_W = 23,
  parameter int DATA_W  = 16,
  parameter int RSEL_W  = 3
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               run,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_code,
  output logic               rf_wr_en,
  output logic [RSEL_W-1:0]  rf_wr_sel,
  output logic [RSEL_W-1:0]  rf_rd_sel,
  output logic [DATA_W-1:0]  imm_out,
  output logic [1:0]         bus_sel,
  output logic               a_load,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               halted,
  output logic [ADDR_W-1:0]  pc
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_W-1:0]    r_pc;
  logic [INSTR_W-1:0]   r_ir;

  logic [3:0]           w_op;
  logic [RSEL_W-1:0]    w_rx;
  logic [RSEL_W-1:0]    w_ry;
  logic                 w_op_legal;

  assign w_op       = r_ir[OP_MSB:OP_LSB];
  assign w_rx       = r_ir[RX_LSB +: RSEL_W];
  assign w_ry       = r_ir[RY_LSB +: RSEL_W];
  assign w_op_legal = (w_op == OP_LOAD) || (w_op == OP_MOV) || (w_op == OP_ADD);

  assign rom_addr = r_pc;
  assign pc       = r_pc;
  assign imm_out  = r_ir[IMM_LSB +: DATA_W];

  // State register, PC and IR. The PC is a plain ADDR_W-bit counter,
  // so incrementing past the last ROM address wraps to 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == FETCH) begin
        r_ir <= rom_code;
        r_pc <= r_pc + ADDR_W'(1);
      end else if ((r_state == HALT) && run) begin
        r_pc <= '0;
      end
    end
  end

  // Next state and Moore decode of state + IR.
  always_comb begin
    w_state_nxt = r_state;
    rf_wr_en    = 1'b0;
    rf_wr_sel   = '0;
    rf_rd_sel   = '0;
    bus_sel     = BUS_NONE;
    a_load      = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;

    case (r_state)
      IDLE: begin
        if (run) w_state_nxt = FETCH;
      end

      FETCH: begin
        w_state_nxt = DECODE;
      end

      DECODE: begin
        if (w_op == OP_HALT) begin
          w_state_nxt = HALT;
        end else if (w_op_legal) begin
          w_state_nxt = EXEC1;
        end else begin
          // Illegal opcodes are flagged and then skipped like a NOP.
          illegal_op  = 1'b1;
          w_state_nxt = FETCH;
        end
      end

      EXEC1: begin
        w_state_nxt = FETCH;
        case (w_op)
          OP_LOAD: begin
            bus_sel    = BUS_IMM;
            rf_wr_sel  = w_rx;
            rf_wr_en   = 1'b1;
            instr_done = 1'b1;
          end
          OP_MOV: begin
            rf_rd_sel  = w_ry;
            bus_sel    = BUS_REG;
            rf_wr_sel  = w_rx;
            rf_wr_en   = 1'b1;
            instr_done = 1'b1;
          end
          OP_ADD: begin
            // First ADD cycle only loads Rx into A; the write happens in EXEC2.
            rf_rd_sel   = w_rx;
            bus_sel     = BUS_REG;
            a_load      = 1'b1;
            w_state_nxt = EXEC2;
          end
          default: ;
        endcase
      end

      EXEC2: begin
        rf_rd_sel   = w_ry;
        bus_sel     = BUS_ALU;
        rf_wr_sel   = w_rx;
        rf_wr_en    = 1'b1;
        instr_done  = 1'b1;
        w_state_nxt = FETCH;
      end

      HALT: begin
        halted = 1'b1;
        if (run) w_state_nxt = FETCH;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed self-checking bench for instr_fetch_decode. A small ROM array
// feeds rom_code combinationally from rom_addr; outputs are sampled 1 ns
// after each rising clock edge.
module tb_instr_fetch_decode;
  import proc_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic [4:0]  rom_addr;
  logic [22:0] rom_code;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_sel;
  logic [2:0]  rf_rd_sel;
  logic [15:0] imm_out;
  logic [1:0]  bus_sel;
  logic        a_load;
  logic        instr_done;
  logic        illegal_op;
  logic        halted;
  logic [4:0]  pc;

  logic [22:0] rom [32];
  assign rom_code = rom[rom_addr];

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;
  int n_ill  = 0;
  int n_clash = 0;

  instr_fetch_decode dut (
    .clock      (clock),
    .resetn     (resetn),
    .run        (run),
    .rom_addr   (rom_addr),
    .rom_code   (rom_code),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_sel  (rf_wr_sel),
    .rf_rd_sel  (rf_rd_sel),
    .imm_out    (imm_out),
    .bus_sel    (bus_sel),
    .a_load     (a_load),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .halted     (halted),
    .pc         (pc)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle and sample; also accumulates pulse statistics.
  task automatic tick();
    @(posedge clock);
    #1;
    if (instr_done === 1'b1) n_done++;
    if (illegal_op === 1'b1) n_ill++;
    if (rf_wr_en === 1'b1 && a_load === 1'b1) n_clash++;
  endtask

  task automatic clr_stats();
    n_done = 0; n_ill = 0; n_clash = 0;
  endtask

  function automatic logic [22:0] mk_load(input logic [2:0] rx, input logic [15:0] imm);
    return {OP_LOAD, rx, imm};
  endfunction

  function automatic logic [22:0] mk_rr(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry, 13'h0};
  endfunction

  initial begin
    resetn = 1'b0;
    run    = 1'b1;
    for (int i = 0; i < 32; i++) rom[i] = {OP_HALT, 19'h0};
    rom[0] = mk_load(3'd0, 16'h000C);
    rom[1] = mk_rr(OP_MOV, 3'd5, 3'd7);
    for (int i = 2; i <= 10; i++) rom[i] = mk_load(3'(i % 8), 16'h0100 + 16'(i));
    rom[11] = mk_rr(OP_ADD, 3'd3, 3'd0);
    rom[12] = {OP_HALT, 19'h0};

    // ---------------- reset state (run held high) ----------------
    @(negedge clock); @(negedge clock);
    chk("rst_pc", pc, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_bus", bus_sel, 0);
    chk("rst_halted", halted, 0);
    chk("rst_done", instr_done, 0);

    // ---------------- program 1 ----------------
    resetn = 1'b1;
    clr_stats();
    tick();                                   // cycle 1: FETCH addr 0
    chk("c1_addr", rom_addr, 0);
    chk("c1_wr_en", rf_wr_en, 0);
    tick();                                   // cycle 2: DECODE
    chk("c2_pc", pc, 1);
    chk("c2_bus", bus_sel, 0);
    run = 1'b0;                               // ignored mid-program
    tick();                                   // cycle 3: LOAD EXEC1
    chk("ld_wr_en", rf_wr_en, 1);
    chk("ld_wr_sel", rf_wr_sel, 0);
    chk("ld_bus", bus_sel, 2'b01);
    chk("ld_imm", imm_out, 16'h000C);
    chk("ld_done", instr_done, 1);
    chk("ld_pc", pc, 1);
    tick(); tick(); tick();                   // cycle 6: MOV EXEC1
    chk("mov_rd", rf_rd_sel, 7);
    chk("mov_wr_sel", rf_wr_sel, 5);
    chk("mov_bus", bus_sel, 2'b10);
    chk("mov_wr_en", rf_wr_en, 1);
    for (int c = 7; c <= 36; c++) tick();     // cycle 36: ADD EXEC1
    chk("add1_rd", rf_rd_sel, 3);
    chk("add1_aload", a_load, 1);
    chk("add1_wr_en", rf_wr_en, 0);
    chk("add1_done", instr_done, 0);
    tick();                                   // cycle 37: ADD EXEC2
    chk("add2_rd", rf_rd_sel, 0);
    chk("add2_bus", bus_sel, 2'b11);
    chk("add2_wr_sel", rf_wr_sel, 3);
    chk("add2_wr_en", rf_wr_en, 1);
    chk("add2_aload", a_load, 0);
    tick(); tick();                           // cycle 39: DECODE of HALT word
    chk("c39_halted", halted, 0);
    tick();                                   // cycle 40: HALT
    chk("halt_halted", halted, 1);
    chk("halt_pc", pc, 13);
    chk("p1_done_cnt", n_done, 12);
    chk("p1_clash", n_clash, 0);
    tick(); tick(); tick();
    chk("halt_pc_frozen", pc, 13);
    chk("halt_stay", halted, 1);

    // ---------------- restart from HALT ----------------
    run = 1'b1;
    tick();
    chk("rst_run_pc", pc, 0);
    chk("rst_run_addr", rom_addr, 0);
    chk("rst_run_halted", halted, 0);
    run = 1'b0;
    tick();
    chk("rst_run_pc1", pc, 1);

    // ---------------- illegal opcodes + PC wrap ----------------
    resetn = 1'b0;
    for (int i = 0; i < 31; i++) rom[i] = {4'b0111, 19'h0};
    rom[31] = mk_load(3'd6, 16'hBEEF);
    run = 1'b1;
    @(negedge clock);
    chk("rst2_pc", pc, 0);
    resetn = 1'b1;
    clr_stats();
    tick();                                   // cycle 1: FETCH
    run = 1'b0;
    tick();                                   // cycle 2: DECODE illegal
    chk("ill_pulse", illegal_op, 1);
    chk("ill_wr_en", rf_wr_en, 0);
    chk("ill_done", instr_done, 0);
    tick();                                   // cycle 3: FETCH addr 1
    chk("ill_next_addr", rom_addr, 1);
    chk("ill_pulse_off", illegal_op, 0);
    for (int c = 4; c <= 62; c++) tick();
    chk("ill_cnt", n_ill, 31);
    chk("ill_no_done", n_done, 0);
    tick();                                   // cycle 63: FETCH addr 31
    chk("wrap_addr31", rom_addr, 31);
    tick();                                   // cycle 64: DECODE
    chk("wrap_pc0", pc, 0);
    tick();                                   // cycle 65: LOAD EXEC1
    chk("wrap_wr_en", rf_wr_en, 1);
    chk("wrap_wr_sel", rf_wr_sel, 6);
    chk("wrap_imm", imm_out, 16'hBEEF);
    chk("wrap_done", instr_done, 1);

    // ---------------- reset during ADD EXEC1 ----------------
    resetn = 1'b0;
    rom[0] = mk_rr(OP_ADD, 3'd3, 3'd0);
    run = 1'b1;
    @(negedge clock);
    resetn = 1'b1;
    clr_stats();
    tick(); tick(); tick();                   // cycle 3: ADD EXEC1
    chk("abort_pre_aload", a_load, 1);
    chk("abort_pre_rd", rf_rd_sel, 3);
    #2 resetn = 1'b0;
    #1;
    chk("abort_aload", a_load, 0);
    chk("abort_pc", pc, 0);
    chk("abort_wr_en", rf_wr_en, 0);
    run = 1'b0;
    tick();
    chk("abort_edge_wr_en", rf_wr_en, 0);
    chk("abort_edge_bus", bus_sel, 0);
    @(negedge clock);
    resetn = 1'b1;
    tick(); tick();
    chk("abort_idle_pc", pc, 0);
    chk("abort_idle_done", n_done, 0);
    chk("abort_idle_wr", rf_wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Consumer end of the 23-bit instruction-ROM interface: owns the program counter, drives the ROM address, captures the returned code word, and sequences the register-file / bus / ALU control strobes for each instruction.
- Sits between the combinational instruction ROM and the processor datapath (register file, bus mux, A register, adder).
- Instruction format: [22:19] opcode, [18:16] Rx, [15:0] imm16 (LOAD) or [15:13] Ry (MOV/ADD).
- Opcodes: 0000 HALT, 0001 LOAD, 0010 MOV, 0011 ADD, 0100–1111 illegal.

Parameters:
ADDR_W, 5, ROM address / PC width
INSTR_W, 23, instruction word width
DATA_W, 16, immediate / datapath width
RSEL_W, 3, register select width

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous, active-low reset
run  in  1  level; start/restart execution from IDLE or HALT
rom_addr  out  ADDR_W  ROM address, equals pc
rom_code  in  INSTR_W  combinational ROM data for rom_addr
rf_wr_en  out  1  register-file write strobe
rf_wr_sel  out  RSEL_W  destination register (Rx)
rf_rd_sel  out  RSEL_W  register-file read select
imm_out  out  DATA_W  immediate field of IR
bus_sel  out  2  bus source: 00 none, 01 imm, 10 reg, 11 alu
a_load  out  1  latch bus/register value into ALU A register
instr_done  out  1  one-cycle pulse in last cycle of each executed instruction
illegal_op  out  1  one-cycle pulse on illegal opcode
halted  out  1  high while in HALT
pc  out  ADDR_W  debug copy of program counter

Behaviour:
- Reset (async, resetn=0): state=IDLE, pc=0, IR=0. All strobes 0, bus_sel=00, halted=0. Reset mid-instruction aborts it; no partial write follows.
- Outputs are a Moore decode of registered state and IR. Every strobe defaults to 0 outside its listed state, and imm_out = IR[15:0] at all times.
- IDLE: if run=1, go to FETCH; otherwise stay.
- FETCH: IR <= rom_code, then pc <= pc+1. At pc=31, pc wraps to 0. Next state DECODE.
- DECODE: no strobes.
  - Opcode 0000 -> HALT.
  - Opcodes 0001/0010/0011 -> EXEC1.
  - Illegal opcode -> pulse illegal_op, then FETCH; it behaves as a NOP with no instr_done.
- EXEC1:
  - LOAD: bus_sel=01, rf_wr_sel=Rx, rf_wr_en=1, instr_done=1; then FETCH.
  - MOV: rf_rd_sel=Ry, bus_sel=10, rf_wr_sel=Rx, rf_wr_en=1, instr_done=1; then FETCH. MOV Rx,Rx is legal (self-write).
  - ADD: rf_rd_sel=Rx, bus_sel=10, a_load=1; then EXEC2.
- EXEC2 (ADD only): rf_rd_sel=Ry, bus_sel=11, rf_wr_sel=Rx, rf_wr_en=1, instr_done=1; then FETCH. The 16-bit sum wraps modulo 2^16; this block provides no carry out.
- Latency, FETCH to last EXEC cycle inclusive: LOAD/MOV 3 cycles, ADD 4 cycles, HALT detected after 2 cycles.
- HALT: halted=1, pc frozen. If run=1, set pc<=0 and go to FETCH, which restarts the program; otherwise stay.
- run is ignored outside IDLE/HALT. Deasserting run mid-program does not stop execution.
- At most one strobe set is active per cycle. rf_wr_en and a_load are never high in the same cycle.

Decomposition:
- Shared package proc_pkg holds:
  - opcode localparams OP_HALT=4'b0000, OP_LOAD=4'b0001, OP_MOV=4'b0010, OP_ADD=4'b0011;
  - bus_sel encodings BUS_NONE/IMM/REG/ALU;
  - state enum IDLE/FETCH/DECODE/EXEC1/EXEC2/HALT;
  - field bit positions.
- The ROM module's case table uses the same package constants.
- No sub-module; PC, IR and FSM live in a single module.

Test Plan:
- Reset with run=1, then release resetn: pc=0, outputs idle during reset. First FETCH on the first edge after reset; rom_addr=0.
- Program word LOAD R0,0x000C at addr 0: in cycle 3, rf_wr_en=1, rf_wr_sel=0, bus_sel=01, imm_out=0x000C, instr_done=1. pc=1 from cycle 2 onward.
- MOV R5,R7 (word {0010,101,111,13'h0}): in EXEC1, rf_rd_sel=7, rf_wr_sel=5, bus_sel=10, rf_wr_en=1.
- ADD R3,R0 at addr 11:
  - EXEC1: rf_rd_sel=3, a_load=1, rf_wr_en=0.
  - EXEC2: rf_rd_sel=0, bus_sel=11, rf_wr_sel=3, rf_wr_en=1.
  - The full 12-instruction program reaches HALT after 39 cycles out of IDLE, with pc=13, halted=1, and 12 instr_done pulses.
- Illegal opcode 4'b0111 at an address: illegal_op pulses once in DECODE with no write strobes. The next FETCH uses the following address.
- Boundary cases:
  - LOAD at addr 31: pc wraps to 0.
  - resetn pulled low during ADD EXEC1: no EXEC2 write occurs; state=IDLE, pc=0.
  - run=1 while halted: pc=0 and execution restarts.
